seg_display_driver: RTL and testbench

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

---
 rtl/seg_display_driver.sv | 96 +++++++++
 tb/tb_seg_display_driver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_driver.sv
// Multiplexed 8-digit seven-segment driver: holds a 32-bit display value,
// scans one hex digit per SCAN_DIV cycles and drives registered digit/segment buses.
module seg_display_driver #(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SegCtrl,
  input  logic [31:0] write_data,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out,
  output logic [31:0] seg_rdata
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [31:0]   r_value;
  logic [PW-1:0] r_presc;
  logic [2:0]    r_digit;
  logic [7:0]    r_seg_en;
  logic [7:0]    r_seg_out;

  logic          w_tick;
  logic [31:0]   w_shifted;
  logic [3:0]    w_nibble;
  logic          w_blank;
  logic [7:0]    w_en_next;
  logic [7:0]    w_out_next;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_tick = (r_presc == PW'(SCAN_DIV - 1));

  // Shifting the current digit down to bit 0 gives both its nibble and,
  // through the remaining upper bits, the leading-zero test in one step.
  always_comb begin
    w_shifted  = r_value >> {r_digit, 2'b00};
    w_nibble   = w_shifted[3:0];
    w_blank    = BLANK_LZ && (r_digit != 3'd0) && (w_shifted == 32'd0);
    w_en_next  = 8'h00;
    w_out_next = 8'h00;
    if (!w_blank) begin
      w_en_next  = 8'h01 << r_digit;
      w_out_next = {1'b0, hex7(w_nibble)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value   <= 32'd0;
      r_presc   <= '0;
      r_digit   <= 3'd0;
      r_seg_en  <= 8'h00;
      r_seg_out <= 8'h00;
    end else begin
      if (SegCtrl) begin
        r_value <= write_data;
      end
      if (w_tick) begin
        r_presc <= '0;
        r_digit <= r_digit + 3'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      r_seg_en  <= w_en_next;
      r_seg_out <= w_out_next;
    end
  end

  assign seg_en    = r_seg_en;
  assign seg_out   = r_seg_out;
  assign seg_rdata = r_value;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with SCAN_DIV=4; one instance with
// leading-zero blanking and one without share the same stimulus.
module tb_seg_display_driver;

  logic        clk;
  logic        rst_n;
  logic        SegCtrl;
  logic [31:0] write_data;
  logic [7:0]  seg_en, seg_out, seg_en_nb, seg_out_nb;
  logic [31:0] seg_rdata, seg_rdata_nb;

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;

  seg_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .SegCtrl(SegCtrl), .write_data(write_data),
    .seg_en(seg_en), .seg_out(seg_out), .seg_rdata(seg_rdata)
  );

  seg_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .SegCtrl(SegCtrl), .write_data(write_data),
    .seg_en(seg_en_nb), .seg_out(seg_out_nb), .seg_rdata(seg_rdata_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ($countones(seg_en) > 1 || $countones(seg_en_nb) > 1) viol++;
  end

  typedef struct {
    logic [31:0] val;
    int          digit;
    logic [7:0]  en1, out1, en0, out0;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst_n released at posedge+1; the next edge is edge k=1.
  task automatic do_reset();
    SegCtrl    = 1'b0;
    write_data = 32'd0;
    rst_n      = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] prev_en;
    int runlen, bad, runs;

    vecs[0]  = '{32'h89ABCDEF, 0, 8'h01, 8'h71, 8'h01, 8'h71};
    vecs[1]  = '{32'h89ABCDEF, 1, 8'h02, 8'h79, 8'h02, 8'h79};
    vecs[2]  = '{32'h89ABCDEF, 2, 8'h04, 8'h5E, 8'h04, 8'h5E};
    vecs[3]  = '{32'h89ABCDEF, 3, 8'h08, 8'h39, 8'h08, 8'h39};
    vecs[4]  = '{32'h89ABCDEF, 4, 8'h10, 8'h7C, 8'h10, 8'h7C};
    vecs[5]  = '{32'h89ABCDEF, 5, 8'h20, 8'h77, 8'h20, 8'h77};
    vecs[6]  = '{32'h89ABCDEF, 6, 8'h40, 8'h6F, 8'h40, 8'h6F};
    vecs[7]  = '{32'h89ABCDEF, 7, 8'h80, 8'h7F, 8'h80, 8'h7F};
    vecs[8]  = '{32'h00000A05, 0, 8'h01, 8'h6D, 8'h01, 8'h6D};
    vecs[9]  = '{32'h00000A05, 1, 8'h02, 8'h3F, 8'h02, 8'h3F};
    vecs[10] = '{32'h00000A05, 2, 8'h04, 8'h77, 8'h04, 8'h77};
    vecs[11] = '{32'h00000A05, 3, 8'h00, 8'h00, 8'h08, 8'h3F};
    vecs[12] = '{32'h00000A05, 5, 8'h00, 8'h00, 8'h20, 8'h3F};
    vecs[13] = '{32'h00000A05, 7, 8'h00, 8'h00, 8'h80, 8'h3F};
    vecs[14] = '{32'h00000000, 0, 8'h01, 8'h3F, 8'h01, 8'h3F};
    vecs[15] = '{32'h00000000, 1, 8'h00, 8'h00, 8'h02, 8'h3F};
    vecs[16] = '{32'h00000000, 7, 8'h00, 8'h00, 8'h80, 8'h3F};
    vecs[17] = '{32'h10000000, 6, 8'h40, 8'h3F, 8'h40, 8'h3F};
    vecs[18] = '{32'h0000B000, 4, 8'h00, 8'h00, 8'h10, 8'h3F};

    rst_n      = 1'b0;
    SegCtrl    = 1'b0;
    write_data = 32'd0;
    #12;
    check("reset_en",    {24'd0, seg_en},  32'h0);
    check("reset_out",   {24'd0, seg_out}, 32'h0);
    check("reset_rdata", seg_rdata,        32'h0);

    // Store during reset is discarded
    SegCtrl    = 1'b1;
    write_data = 32'h55;
    step();
    check("reset_store_dropped", seg_rdata, 32'h0);
    SegCtrl = 1'b0;

    // First edge after release, then rest of slot 0 and blanked slot 1
    do_reset();
    step();
    check("first_en",  {24'd0, seg_en},  32'h01);
    check("first_out", {24'd0, seg_out}, 32'h3F);
    repeat (3) step();
    check("slot0_last_en", {24'd0, seg_en}, 32'h01);
    step();
    check("slot1_blank_en",  {24'd0, seg_en},  32'h00);
    check("slot1_blank_out", {24'd0, seg_out}, 32'h00);
    repeat (28) step();
    check("wrap_slot0_en", {24'd0, seg_en}, 32'h01);

    // Table: store on edge 1, inspect digit d at edge 4d+2
    for (int i = 0; i < 19; i++) begin
      do_reset();
      SegCtrl    = 1'b1;
      write_data = vecs[i].val;
      step();
      SegCtrl = 1'b0;
      check($sformatf("vec%0d_rdata", i), seg_rdata, vecs[i].val);
      check($sformatf("vec%0d_rdata_nb", i), seg_rdata_nb, vecs[i].val);
      repeat (4 * vecs[i].digit + 1) step();
      check($sformatf("vec%0d_en", i),     {24'd0, seg_en},     {24'd0, vecs[i].en1});
      check($sformatf("vec%0d_out", i),    {24'd0, seg_out},    {24'd0, vecs[i].out1});
      check($sformatf("vec%0d_en_nb", i),  {24'd0, seg_en_nb},  {24'd0, vecs[i].en0});
      check($sformatf("vec%0d_out_nb", i), {24'd0, seg_out_nb}, {24'd0, vecs[i].out0});
    end

    // Store coincident with the 0->1 index tick
    do_reset();
    repeat (3) step();
    SegCtrl    = 1'b1;
    write_data = 32'h12;
    step();
    SegCtrl = 1'b0;
    check("tick_store_old_en",  {24'd0, seg_en},  32'h01);
    check("tick_store_old_out", {24'd0, seg_out}, 32'h3F);
    step();
    check("tick_store_new_en",  {24'd0, seg_en},  32'h02);
    check("tick_store_new_out", {24'd0, seg_out}, 32'h06);

    // Back-to-back stores, last wins, scan not disturbed
    do_reset();
    repeat (5) step();
    SegCtrl    = 1'b1;
    write_data = 32'h11111111;
    step();
    write_data = 32'hFFFFFFFF;
    step();
    SegCtrl = 1'b0;
    check("b2b_rdata", seg_rdata, 32'hFFFFFFFF);
    check("b2b_first_out", {24'd0, seg_out}, 32'h06);
    step();
    check("b2b_hold_en",  {24'd0, seg_en},  32'h02);
    check("b2b_hold_out", {24'd0, seg_out}, 32'h71);
    step();
    check("b2b_next_en", {24'd0, seg_en}, 32'h04);

    // Asynchronous partial-cycle reset during digit 5
    do_reset();
    SegCtrl    = 1'b1;
    write_data = 32'hFFFFFFFF;
    step();
    SegCtrl = 1'b0;
    repeat (21) step();
    check("mid_pre_en", {24'd0, seg_en}, 32'h20);
    #2 rst_n = 1'b0;
    #1;
    check("mid_async_en",    {24'd0, seg_en},  32'h00);
    check("mid_async_out",   {24'd0, seg_out}, 32'h00);
    check("mid_async_rdata", seg_rdata,        32'h0);
    #2 rst_n = 1'b1;
    step();
    check("mid_rel_en",  {24'd0, seg_en},  32'h01);
    check("mid_rel_out", {24'd0, seg_out}, 32'h3F);
    repeat (3) step();
    check("mid_k4_en_nb", {24'd0, seg_en_nb}, 32'h01);
    step();
    check("mid_k5_en_nb", {24'd0, seg_en_nb}, 32'h02);

    // Random stores: every slot on the unblanked instance lasts 4 cycles
    do_reset();
    prev_en = 8'h00;
    runlen  = 0;
    bad     = 0;
    runs    = 0;
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(7) == 0) begin
        SegCtrl    = 1'b1;
        write_data = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
      end else begin
        SegCtrl = 1'b0;
      end
      step();
      if (seg_en_nb == prev_en) begin
        runlen++;
      end else begin
        if (prev_en != 8'h00) begin
          runs++;
          if (runlen != 4) bad++;
        end
        prev_en = seg_en_nb;
        runlen  = 1;
      end
    end
    SegCtrl = 1'b0;
    check("slot_period_bad", bad,  0);
    check("slot_runs",       runs, 74);
    check("onehot_viol",     viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
